// File: rtl/wb_interconnect_pkg.sv
// Shared definitions for the Wishbone interconnect.
//   - 3-bit FSM state codes used by wb_interconnect
//   - default address map: RAM, SDRAM controller and peripheral block
package wb_interconnect_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle = 3'd0;
   localparam state_t StReq  = 3'd1;
   localparam state_t StWait = 3'd2;
   localparam state_t StResp = 3'd3;
   localparam state_t StErr  = 3'd4;

   localparam logic [31:0] RAM_BASE    = 32'hb000_0000;
   localparam logic [31:0] RAM_MASK    = 32'hffff_0000;
   localparam logic [31:0] SDRAM_BASE  = 32'h4000_0000;
   localparam logic [31:0] SDRAM_MASK  = 32'hf000_0000;
   localparam logic [31:0] PERIPH_BASE = 32'hc000_0000;
   localparam logic [31:0] PERIPH_MASK = 32'hff00_0000;

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder.
// Slave k hits when (addr & MASK[k]) == BASE[k]; the lowest matching index wins.
// Ports:
//   addr  in   32        address to decode
//   sel   out  N_SLAVES  one-hot slave select (all zero on a miss)
//   hit   out  1         some slave matched
module wb_addr_decoder
   import wb_interconnect_pkg::*;
#(
   parameter int unsigned             N_SLAVES   = 3,
   parameter logic [32*N_SLAVES-1:0] SLAVE_BASE = {PERIPH_BASE, SDRAM_BASE, RAM_BASE},
   parameter logic [32*N_SLAVES-1:0] SLAVE_MASK = {PERIPH_MASK, SDRAM_MASK, RAM_MASK}
) (
   input  logic [31:0]         addr,
   output logic [N_SLAVES-1:0] sel,
   output logic                hit
);

   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int unsigned k = 0; k < N_SLAVES; k++) begin
         // once a lower index has matched, higher indices are masked off
         if (!hit && ((addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32])) begin
            sel[k] = 1'b1;
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, N-slave pipelined Wishbone interconnect.
// Routes one transaction at a time to the decoded slave and returns ack/data, or an
// error on unmapped addresses and on slave timeout.
// Ports:
//   clk, reset (async, active low)
//   i_wb_cyc/stb/we/addr/data   master request
//   o_wb_data/ack/err/stall     master response
//   o_s_cyc/stb [N_SLAVES]      per-slave cycle/strobe
//   o_s_we/addr/data            shared slave request fields (latched)
//   i_s_data/ack/stall          per-slave responses (slave k data at bits 32k+31:32k)
module wb_interconnect
   import wb_interconnect_pkg::*;
#(
   parameter int unsigned             N_SLAVES   = 3,
   parameter logic [32*N_SLAVES-1:0] SLAVE_BASE = {PERIPH_BASE, SDRAM_BASE, RAM_BASE},
   parameter logic [32*N_SLAVES-1:0] SLAVE_MASK = {PERIPH_MASK, SDRAM_MASK, RAM_MASK},
   parameter int unsigned             TIMEOUT    = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_wb_cyc,
   input  logic                     i_wb_stb,
   input  logic                     i_wb_we,
   input  logic [31:0]              i_wb_addr,
   input  logic [31:0]              i_wb_data,
   output logic [31:0]              o_wb_data,
   output logic                     o_wb_ack,
   output logic                     o_wb_err,
   output logic                     o_wb_stall,
   output logic [N_SLAVES-1:0]      o_s_cyc,
   output logic [N_SLAVES-1:0]      o_s_stb,
   output logic                     o_s_we,
   output logic [31:0]              o_s_addr,
   output logic [31:0]              o_s_data,
   input  logic [32*N_SLAVES-1:0]   i_s_data,
   input  logic [N_SLAVES-1:0]      i_s_ack,
   input  logic [N_SLAVES-1:0]      i_s_stall
);

   // Counter holds the number of cycles already spent in REQ/WAIT, so the error
   // fires after exactly TIMEOUT cycles of slave cycle without an ack.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [31:0]         addr_q, data_q, rdata_q, sel_rdata;
   logic                we_q;
   logic [N_SLAVES-1:0] sel_q, dec_sel;
   logic [7:0]          cnt_q;
   logic                dec_hit, req, sel_ack, sel_stall, timed_out, busy;

   wb_addr_decoder #(
      .N_SLAVES   (N_SLAVES),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_decoder (
      .addr (i_wb_addr),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

   assign req       = i_wb_cyc & i_wb_stb;
   // only the latched slave's handshakes matter
   assign sel_ack   = |(i_s_ack & sel_q);
   assign sel_stall = |(i_s_stall & sel_q);
   assign timed_out = (cnt_q == TIMEOUT_LAST);
   assign busy      = (state_q == StReq) || (state_q == StWait);

   always_comb begin
      sel_rdata = '0;
      for (int unsigned k = 0; k < N_SLAVES; k++) begin
         if (sel_q[k]) sel_rdata = sel_rdata | i_s_data[32*k +: 32];
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic; a master abort outranks ack and timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (req) state_d = dec_hit ? StReq : StErr;
         StReq: begin
            if (!i_wb_cyc)                 state_d = StIdle;
            else if (!sel_stall && sel_ack) state_d = StResp;
            else if (timed_out)            state_d = StErr;
            else if (!sel_stall)           state_d = StWait;
         end
         StWait: begin
            if (!i_wb_cyc)      state_d = StIdle;
            else if (sel_ack)   state_d = StResp;
            else if (timed_out) state_d = StErr;
         end
         StResp:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      o_wb_stall = (state_q != StIdle);
      o_wb_ack   = (state_q == StResp);
      o_wb_err   = (state_q == StErr);
      o_s_cyc    = '0;
      o_s_stb    = '0;
      unique case (state_q)
         StReq: begin
            o_s_cyc = sel_q;
            o_s_stb = sel_q;
         end
         StWait:  o_s_cyc = sel_q;
         default: ;
      endcase
   end

   assign o_s_we    = we_q;
   assign o_s_addr  = addr_q;
   assign o_s_data  = data_q;
   assign o_wb_data = rdata_q;

   // Request latches, timeout counter and read-data capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         cnt_q <= busy ? cnt_q + 8'd1 : 8'd0;
         if (state_q == StIdle && req) begin
            addr_q <= i_wb_addr;
            data_q <= i_wb_data;
            we_q   <= i_wb_we;
            sel_q  <= dec_sel;
         end
         if (state_d == StResp) rdata_q <= sel_rdata;
      end
   end

endmodule

// File: tb/tb_wb_interconnect.sv
// Self-checking bench for wb_interconnect: directed scenarios plus randomized
// transactions, each judged against a transaction-level model of the address map
// and the latency/timeout rules.
module tb_wb_interconnect;

   localparam int NS  = 3;
   localparam int TMO = 255;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_wb_cyc, i_wb_stb, i_wb_we;
   logic [31:0]       i_wb_addr, i_wb_data;
   logic [31:0]       o_wb_data;
   logic              o_wb_ack, o_wb_err, o_wb_stall;
   logic [NS-1:0]     o_s_cyc, o_s_stb;
   logic              o_s_we;
   logic [31:0]       o_s_addr, o_s_data;
   logic [32*NS-1:0]  i_s_data;
   logic [NS-1:0]     i_s_ack, i_s_stall;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_rdata;
   logic [31:0] map_base [NS];
   logic [31:0] map_mask [NS];

   always #5 clk = ~clk;

   wb_interconnect #(
      .N_SLAVES (NS),
      .TIMEOUT  (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_wb_cyc   (i_wb_cyc),
      .i_wb_stb   (i_wb_stb),
      .i_wb_we    (i_wb_we),
      .i_wb_addr  (i_wb_addr),
      .i_wb_data  (i_wb_data),
      .o_wb_data  (o_wb_data),
      .o_wb_ack   (o_wb_ack),
      .o_wb_err   (o_wb_err),
      .o_wb_stall (o_wb_stall),
      .o_s_cyc    (o_s_cyc),
      .o_s_stb    (o_s_stb),
      .o_s_we     (o_s_we),
      .o_s_addr   (o_s_addr),
      .o_s_data   (o_s_data),
      .i_s_data   (i_s_data),
      .i_s_ack    (i_s_ack),
      .i_s_stall  (i_s_stall)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference decode: first slave whose masked address equals its base, -1 if none.
   function automatic int decode(input logic [31:0] a);
      for (int k = 0; k < NS; k++) begin
         if ((a & map_mask[k]) == map_base[k]) return k;
      end
      return -1;
   endfunction

   // One master transaction starting in cycle 0 (called just after a rising edge).
   // The selected slave stalls s_n cycles, then acks d_n cycles after acceptance
   // (plus a duplicate ack the cycle after). Unselected slaves emit random noise.
   task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input int s_n, input int d_n,
                          input bit no_ack, input int abort_at, input logic [31:0] rdata);
      int            k, busy_n, exp_ack_c, exp_err_c, exp_stb_n, exp_cyc_n, end_c;
      int            ack_c, err_c, ack_n, err_n, stb_n, cyc_n, stray;
      logic [NS-1:0] sel, ab_cyc;
      logic [31:0]   s_addr, s_data, r;
      logic          s_we, stall0, stall1, ab_stall;
      bit            done;

      k = decode(addr);
      sel = '0;
      if (k >= 0) sel[k] = 1'b1;

      // Model: cycles in REQ+WAIT up to and including the ack cycle
      busy_n = s_n + d_n + 1;
      exp_ack_c = -1;
      exp_err_c = -1;
      exp_stb_n = 0;
      exp_cyc_n = 0;
      if (k < 0) begin
         exp_err_c = 1;
      end else if (abort_at >= 0) begin
         exp_cyc_n = abort_at;
         exp_stb_n = (s_n + 1 < abort_at) ? s_n + 1 : abort_at;
      end else if (no_ack || busy_n > TMO) begin
         exp_err_c = TMO + 1;
         exp_cyc_n = TMO;
         exp_stb_n = (s_n + 1 < TMO) ? s_n + 1 : TMO;
      end else begin
         exp_ack_c = busy_n + 1;
         exp_cyc_n = busy_n;
         exp_stb_n = s_n + 1;
      end
      if (abort_at >= 0)     end_c = abort_at + 4;
      else if (exp_ack_c > 0) end_c = exp_ack_c + 3;
      else                   end_c = exp_err_c + 3;

      ack_c = -1; err_c = -1; ack_n = 0; err_n = 0; stb_n = 0; cyc_n = 0; stray = 0;
      done = 0; s_addr = '0; s_data = '0; s_we = 1'b0; stall0 = 1'b1; stall1 = 1'b0;
      ab_cyc = '1; ab_stall = 1'b1;

      i_wb_cyc  = 1'b1;
      i_wb_stb  = 1'b1;
      i_wb_we   = we;
      i_wb_addr = addr;
      i_wb_data = wdata;
      for (int c = 0; c <= end_c; c++) begin
         if (c > 0) begin
            // scramble master fields so only latched values can reach the slaves
            i_wb_stb  = 1'b0;
            i_wb_addr = $urandom;
            i_wb_data = $urandom;
            r = $urandom;
            i_wb_we = r[0];
            if (done || (abort_at >= 0 && c >= abort_at)) i_wb_cyc = 1'b0;
         end
         for (int j = 0; j < NS; j++) i_s_data[32*j +: 32] = $urandom;
         r = $urandom;
         i_s_ack   = r[NS-1:0];
         i_s_stall = r[NS+7:8];
         if (k >= 0) begin
            i_s_stall[k] = (c >= 1 && c <= s_n);
            i_s_ack[k]   = !no_ack && (c == 1 + s_n + d_n || c == 2 + s_n + d_n);
            if (i_s_ack[k]) i_s_data[32*k +: 32] = rdata;
         end

         @(negedge clk);
         if (o_wb_ack) begin ack_n++; if (ack_c < 0) ack_c = c; done = 1; end
         if (o_wb_err) begin err_n++; if (err_c < 0) err_c = c; done = 1; end
         if ((o_s_stb & sel) != '0) stb_n++;
         if ((o_s_cyc & sel) != '0) cyc_n++;
         if (((o_s_cyc | o_s_stb) & ~sel) != '0) stray++;
         if (c == 0) stall0 = o_wb_stall;
         if (c == 1) begin
            stall1 = o_wb_stall;
            s_addr = o_s_addr;
            s_data = o_s_data;
            s_we   = o_s_we;
         end
         if (c == abort_at + 1) begin
            ab_cyc   = o_s_cyc;
            ab_stall = o_wb_stall;
         end
         @(posedge clk);
         #1;
      end
      i_wb_cyc = 1'b0;

      if (exp_ack_c > 0) exp_rdata = rdata;

      check($sformatf("%s ack_cycle", tag), ack_c, exp_ack_c);
      check($sformatf("%s ack_count", tag), ack_n, (exp_ack_c > 0) ? 1 : 0);
      check($sformatf("%s err_cycle", tag), err_c, exp_err_c);
      check($sformatf("%s err_count", tag), err_n, (exp_err_c > 0) ? 1 : 0);
      check($sformatf("%s stb_cycles", tag), stb_n, exp_stb_n);
      check($sformatf("%s cyc_cycles", tag), cyc_n, exp_cyc_n);
      check($sformatf("%s stray_select", tag), stray, 0);
      check($sformatf("%s rdata", tag), o_wb_data, exp_rdata);
      check($sformatf("%s stall_idle", tag), 32'(stall0), 0);
      check($sformatf("%s stall_busy", tag), 32'(stall1), 1);
      check($sformatf("%s s_addr", tag), s_addr, addr);
      check($sformatf("%s s_data", tag), s_data, wdata);
      check($sformatf("%s s_we", tag), 32'(s_we), 32'(we));
      if (abort_at >= 0) begin
         check($sformatf("%s abort_cyc", tag), 32'(ab_cyc), 0);
         check($sformatf("%s abort_stall", tag), 32'(ab_stall), 0);
      end
   endtask

   task automatic check_quiet(input string tag);
      check($sformatf("%s ack", tag), 32'(o_wb_ack), 0);
      check($sformatf("%s err", tag), 32'(o_wb_err), 0);
      check($sformatf("%s stall", tag), 32'(o_wb_stall), 0);
      check($sformatf("%s s_cyc", tag), 32'(o_s_cyc), 0);
      check($sformatf("%s s_stb", tag), 32'(o_s_stb), 0);
      check($sformatf("%s s_we", tag), 32'(o_s_we), 0);
      check($sformatf("%s s_addr", tag), o_s_addr, 0);
      check($sformatf("%s s_data", tag), o_s_data, 0);
      check($sformatf("%s wb_data", tag), o_wb_data, 0);
   endtask

   initial begin
      logic [31:0] a, r;
      int          region;

      // slave 0 is the least-significant word of SLAVE_BASE: RAM, then SDRAM, then peripherals
      map_base[0] = 32'hb000_0000; map_mask[0] = 32'hffff_0000;
      map_base[1] = 32'h4000_0000; map_mask[1] = 32'hf000_0000;
      map_base[2] = 32'hc000_0000; map_mask[2] = 32'hff00_0000;

      exp_rdata = '0;
      reset     = 1'b1;
      i_wb_cyc  = 1'b0;
      i_wb_stb  = 1'b0;
      i_wb_we   = 1'b0;
      i_wb_addr = '0;
      i_wb_data = '0;
      i_s_data  = '0;
      i_s_ack   = '0;
      i_s_stall = '0;
      #2 reset = 1'b0;
      #10;
      check_quiet("reset");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      run_txn("ram_read", 32'hb000_0010, 1'b0, 32'h0bad_f00d, 0, 1, 1'b0, -1, 32'hdead_beef);
      run_txn("sdram_write", 32'h4000_0100, 1'b1, 32'h1234_5678, 4, 1, 1'b0, -1, 32'h0a0b_0c0d);
      run_txn("unmapped", 32'h0000_0000, 1'b0, 32'h5555_aaaa, 0, 0, 1'b0, -1, 32'h1111_2222);
      run_txn("periph_timeout", 32'hc000_0000, 1'b0, 32'h7777_8888, 0, 0, 1'b1, -1, 32'h3333_4444);
      run_txn("abort", 32'hb000_0020, 1'b0, 32'h0, 0, 2, 1'b0, 2, 32'hcafe_babe);
      run_txn("after_abort", 32'hc012_3456, 1'b1, 32'h9abc_def0, 1, 0, 1'b0, -1, 32'h600d_d00d);

      // reset while the SDRAM slave is in its wait phase
      i_wb_cyc  = 1'b1;
      i_wb_stb  = 1'b1;
      i_wb_we   = 1'b0;
      i_wb_addr = 32'h4000_0abc;
      i_wb_data = 32'h2468_ace0;
      i_s_ack   = '0;
      i_s_stall = '0;
      @(posedge clk);
      #1;
      i_wb_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_pre_wait_cyc", 32'(o_s_cyc), 32'h2);
      reset = 1'b0;
      #1;
      check_quiet("rst_mid");
      exp_rdata = '0;
      @(negedge clk);
      i_wb_cyc = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_stall", 32'(o_wb_stall), 0);
      run_txn("post_reset_read", 32'hb000_0040, 1'b0, 32'h0, 0, 1, 1'b0, -1, 32'h8765_4321);

      for (int t = 0; t < 24; t++) begin
         region = $urandom_range(0, 3);
         r = $urandom;
         case (region)
            0:       a = 32'hb000_0000 | (r & 32'h0000_ffff);
            1:       a = 32'h4000_0000 | (r & 32'h0fff_ffff);
            2:       a = 32'hc000_0000 | (r & 32'h00ff_ffff);
            default: a = r & 32'h0fff_ffff;
         endcase
         r = $urandom;
         run_txn($sformatf("rand%0d", t), a, r[0], $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'b0, -1, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
